gbe_rx_valid_counter: RTL and testbench

//   Counts receive activity on the 10GbE core's user-side RX interface (valid words, completed frames, errored frames).

---
 rtl/gbe_rx_pkg.sv | 19 +
 rtl/gbe_sat_counter.sv | 38 +++
 rtl/gbe_rx_valid_counter.sv | 141 ++++++++++++++
 tb/tb_gbe_rx_valid_counter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gbe_rx_pkg.sv
// Shared types and defaults for the 10GbE RX activity counters.
package gbe_rx_pkg;

  // Default width of every count word handed to the status registers.
  localparam int CTR_WIDTH_DEFAULT = 32;

  // Frame-tracking state of the RX user interface.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DROP     = 2'd2
  } gbe_rx_state_t;

  // True while a frame has started and its eof word has not yet been seen.
  function automatic logic state_in_frame(input gbe_rx_state_t st);
    return (st != IDLE);
  endfunction

endpackage

// File: rtl/gbe_sat_counter.sv
// Single event counter with synchronous clear and selectable wrap/saturate.
module gbe_sat_counter #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             user_clk,
  input  logic             user_rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;

  assign count = r_count;

  // Count register: reset and clear win over increment; at the top value either hold or wrap.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_count <= ZERO;
    end else if (clr) begin
      r_count <= ZERO;
    end else if (inc) begin
      if (SATURATE && (r_count == MAX)) begin
        r_count <= MAX;
      end else begin
        r_count <= r_count + ONE;
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/gbe_rx_valid_counter.sv
// RX activity counters for the 10GbE user interface: valid words, good frames,
// and bad or overrun-dropped frames, all in the user_clk domain.
module gbe_rx_valid_counter
  import gbe_rx_pkg::*;
#(
  parameter int CTR_WIDTH = CTR_WIDTH_DEFAULT,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  input  logic                 rx_valid,
  input  logic                 rx_end_of_frame,
  input  logic                 rx_bad_frame,
  input  logic                 rx_overrun,
  input  logic                 ctr_rst,
  input  logic                 ctr_en,
  output logic [CTR_WIDTH-1:0] rx_vld_count,
  output logic [CTR_WIDTH-1:0] rx_eof_count,
  output logic [CTR_WIDTH-1:0] rx_err_count,
  output logic                 rx_in_frame
);

  gbe_rx_state_t r_state;
  gbe_rx_state_t w_state_nxt;
  logic          r_ctr_rst_d;
  logic          w_clr;
  logic          w_eow;
  logic          w_cnt_ok;
  logic          w_eof_hit;
  logic          w_err_hit;
  logic          w_inc_vld;
  logic          w_inc_eof;
  logic          w_inc_err;

  // Delay starts at 1 out of reset so a clear held across reset does not fire.
  assign w_clr    = ctr_rst & ~r_ctr_rst_d;
  assign w_eow    = rx_valid & rx_end_of_frame;
  assign w_cnt_ok = ctr_en & ~w_clr;

  // State register and software-clear edge detector.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state     <= IDLE;
      r_ctr_rst_d <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_ctr_rst_d <= ctr_rst;
    end
  end

  // Next-state decode; counting enables and clears never affect frame tracking.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (rx_valid & ~rx_end_of_frame) begin
          w_state_nxt = rx_overrun ? DROP : IN_FRAME;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      IN_FRAME: begin
        if (w_eow) begin
          w_state_nxt = IDLE;
        end else if (rx_overrun) begin
          w_state_nxt = DROP;
        end else begin
          w_state_nxt = IN_FRAME;
        end
      end
      DROP: begin
        if (w_eow) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DROP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame event decode: an overrun in a frame costs exactly one err and suppresses its eof.
  always_comb begin
    w_eof_hit = 1'b0;
    w_err_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_eow) begin
          w_eof_hit = ~rx_bad_frame;
          w_err_hit = rx_bad_frame;
        end else if (rx_valid & rx_overrun) begin
          w_err_hit = 1'b1;
        end else begin
          w_err_hit = 1'b0;
        end
      end
      IN_FRAME: begin
        if (rx_overrun) begin
          w_err_hit = 1'b1;
        end else if (w_eow) begin
          w_eof_hit = ~rx_bad_frame;
          w_err_hit = rx_bad_frame;
        end else begin
          w_err_hit = 1'b0;
        end
      end
      DROP:    w_err_hit = 1'b0;
      default: w_err_hit = 1'b0;
    endcase
  end

  assign w_inc_vld   = rx_valid  & w_cnt_ok;
  assign w_inc_eof   = w_eof_hit & w_cnt_ok;
  assign w_inc_err   = w_err_hit & w_cnt_ok;
  assign rx_in_frame = state_in_frame(r_state);

  gbe_sat_counter #(.WIDTH(CTR_WIDTH), .SATURATE(SATURATE)) u_vld_ctr (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .clr      (w_clr),
    .inc      (w_inc_vld),
    .count    (rx_vld_count)
  );

  gbe_sat_counter #(.WIDTH(CTR_WIDTH), .SATURATE(SATURATE)) u_eof_ctr (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .clr      (w_clr),
    .inc      (w_inc_eof),
    .count    (rx_eof_count)
  );

  gbe_sat_counter #(.WIDTH(CTR_WIDTH), .SATURATE(SATURATE)) u_err_ctr (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .clr      (w_clr),
    .inc      (w_inc_err),
    .count    (rx_err_count)
  );

endmodule

// File: tb/tb_gbe_rx_valid_counter.sv
// Scoreboard bench for gbe_rx_valid_counter: stimulus pushes hand-computed
// expectations tagged with the clock edge they apply to; a negedge monitor pops them.
module tb_gbe_rx_valid_counter;

  logic        clk = 1'b0;
  logic        user_rst;
  logic        rx_valid, rx_end_of_frame, rx_bad_frame, rx_overrun;
  logic        ctr_rst, ctr_en;
  logic [31:0] vld_cnt, eof_cnt, err_cnt;
  logic        in_frame;
  logic [3:0]  v4s0, e4s0, r4s0, v4s1, e4s1, r4s1;
  logic        f4s0, f4s1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  typedef struct {
    int          due;
    string       name;
    bit          ck_cnt;
    logic [31:0] vld, eof, err;
    bit          ck_inf;
    logic        inf;
    bit          ck_w4;
    logic [3:0]  s0, s1;
  } exp_t;

  exp_t q[$];

  gbe_rx_valid_counter #(.CTR_WIDTH(32), .SATURATE(1'b0)) u_dut (
    .user_clk(clk), .user_rst(user_rst), .rx_valid(rx_valid),
    .rx_end_of_frame(rx_end_of_frame), .rx_bad_frame(rx_bad_frame),
    .rx_overrun(rx_overrun), .ctr_rst(ctr_rst), .ctr_en(ctr_en),
    .rx_vld_count(vld_cnt), .rx_eof_count(eof_cnt), .rx_err_count(err_cnt),
    .rx_in_frame(in_frame)
  );

  gbe_rx_valid_counter #(.CTR_WIDTH(4), .SATURATE(1'b0)) u_w4_wrap (
    .user_clk(clk), .user_rst(user_rst), .rx_valid(rx_valid),
    .rx_end_of_frame(rx_end_of_frame), .rx_bad_frame(rx_bad_frame),
    .rx_overrun(rx_overrun), .ctr_rst(ctr_rst), .ctr_en(ctr_en),
    .rx_vld_count(v4s0), .rx_eof_count(e4s0), .rx_err_count(r4s0),
    .rx_in_frame(f4s0)
  );

  gbe_rx_valid_counter #(.CTR_WIDTH(4), .SATURATE(1'b1)) u_w4_sat (
    .user_clk(clk), .user_rst(user_rst), .rx_valid(rx_valid),
    .rx_end_of_frame(rx_end_of_frame), .rx_bad_frame(rx_bad_frame),
    .rx_overrun(rx_overrun), .ctr_rst(ctr_rst), .ctr_en(ctr_en),
    .rx_vld_count(v4s1), .rx_eof_count(e4s1), .rx_err_count(r4s1),
    .rx_in_frame(f4s1)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to tag expectations.
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Monitor: pops the expectation due for the most recent edge and compares.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc_n) begin
      e = q.pop_front();
      if (e.due < cyc_n) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: stale expectation for edge %0d at edge %0d", e.name, e.due, cyc_n);
      end else begin
        if (e.ck_cnt) begin
          cmp({e.name, ".vld"}, vld_cnt, e.vld);
          cmp({e.name, ".eof"}, eof_cnt, e.eof);
          cmp({e.name, ".err"}, err_cnt, e.err);
        end
        if (e.ck_inf) cmp({e.name, ".in_frame"}, {31'd0, in_frame}, {31'd0, e.inf});
        if (e.ck_w4) begin
          cmp({e.name, ".w4_wrap"}, {28'd0, v4s0}, {28'd0, e.s0});
          cmp({e.name, ".w4_sat"},  {28'd0, v4s1}, {28'd0, e.s1});
        end
      end
    end
  end

  // Apply one cycle of RX inputs and let the DUT sample it.
  task automatic drive(input logic v, input logic e, input logic b, input logic o);
    rx_valid = v; rx_end_of_frame = e; rx_bad_frame = b; rx_overrun = o;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cnt(input string name, input logic [31:0] v, input logic [31:0] e,
                         input logic [31:0] r, input logic inf);
    exp_t x;
    x = '{due: cyc_n, name: name, ck_cnt: 1'b1, vld: v, eof: e, err: r,
          ck_inf: 1'b1, inf: inf, ck_w4: 1'b0, s0: 4'd0, s1: 4'd0};
    q.push_back(x);
  endtask

  task automatic exp_inf(input string name, input logic inf);
    exp_t x;
    x = '{due: cyc_n, name: name, ck_cnt: 1'b0, vld: 32'd0, eof: 32'd0, err: 32'd0,
          ck_inf: 1'b1, inf: inf, ck_w4: 1'b0, s0: 4'd0, s1: 4'd0};
    q.push_back(x);
  endtask

  task automatic exp_w4(input string name, input logic [3:0] s0, input logic [3:0] s1);
    exp_t x;
    x = '{due: cyc_n, name: name, ck_cnt: 1'b0, vld: 32'd0, eof: 32'd0, err: 32'd0,
          ck_inf: 1'b0, inf: 1'b0, ck_w4: 1'b1, s0: s0, s1: s1};
    q.push_back(x);
  endtask

  // Software clear pulse with the RX interface idle.
  task automatic clear_all();
    ctr_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ctr_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Directed stimulus.
  initial begin
    user_rst = 1'b1; ctr_rst = 1'b0; ctr_en = 1'b1;
    rx_valid = 1'b0; rx_end_of_frame = 1'b0; rx_bad_frame = 1'b0; rx_overrun = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp_cnt("reset", 32'd0, 32'd0, 32'd0, 1'b0);
    exp_w4("reset_w4", 4'd0, 4'd0);
    user_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // 1: good frames of 4, 1 and 8 words
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_cnt("t1_first_word", 32'd1, 32'd0, 32'd0, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t1_frame4", 32'd4, 32'd1, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t1_frame1", 32'd5, 32'd2, 32'd0, 1'b0);
    repeat (7) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t1_total", 32'd13, 32'd3, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // 2: 6-word bad frame
    clear_all();
    exp_cnt("t2_cleared", 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp_inf("t2_in_frame", 1'b1);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    exp_cnt("t2_bad", 32'd6, 32'd0, 32'd1, 1'b0);

    // 3: overrun on word 3 of 10, then a good 2-word frame
    clear_all();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    exp_cnt("t3_overrun", 32'd3, 32'd0, 32'd1, 1'b1);
    repeat (6) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t3_drop_end", 32'd10, 32'd0, 32'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t3_good2", 32'd12, 32'd1, 32'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp_cnt("t3_idle_ovr", 32'd12, 32'd1, 32'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    exp_cnt("t3_eof_ovr", 32'd14, 32'd1, 32'd2, 1'b0);

    // 4: clear edge detection
    clear_all();
    repeat (7) drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t4_seven", 32'd7, 32'd7, 32'd0, 1'b0);
    ctr_rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t4_clear", 32'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t4_held1", 32'd1, 32'd1, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t4_held2", 32'd2, 32'd2, 32'd0, 1'b0);
    ctr_rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t4_low", 32'd3, 32'd3, 32'd0, 1'b0);
    ctr_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp_cnt("t4_retoggle", 32'd0, 32'd0, 32'd0, 1'b0);
    ctr_rst = 1'b0;
    // counting disabled mid-frame: frame still tracked
    ctr_en = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_cnt("t4_en_off", 32'd0, 32'd0, 32'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    ctr_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t4_en_on_eof", 32'd1, 32'd1, 32'd0, 1'b0);

    // 5: 4-bit wrap vs saturate
    clear_all();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 15) exp_w4("t5_w15", 4'd15, 4'd15);
      if (i == 16) exp_w4("t5_w16", 4'd0, 4'd15);
      if (i == 17) exp_w4("t5_w17", 4'd1, 4'd15);
    end

    // 6: reset mid-frame with ctr_rst held high across reset
    clear_all();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_cnt("t6_mid", 32'd2, 32'd0, 32'd0, 1'b1);
    ctr_rst = 1'b1;
    user_rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_cnt("t6_reset", 32'd0, 32'd0, 32'd0, 1'b0);
    user_rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_cnt("t6_word1", 32'd1, 32'd0, 32'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t6_frame", 32'd3, 32'd1, 32'd0, 1'b0);
    ctr_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
